// File: rtl/pong_state_engine_if.sv
// State-RAM write port driven by the pong game engine and read back by the
// layer-1 tile generator side of the dual-port RAM.
interface pong_state_engine_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic          we;
  logic [AW-1:0] address;
  logic [DW-1:0] data;

  modport master (output we, address, data);
  modport slave  (input  we, address, data);
endinterface

// File: rtl/pong_state_engine.sv
// Per-frame pong game logic: moves paddles and ball, scores misses, then
// streams the 8-byte game-state record into the state RAM.
module pong_state_engine #(
  parameter int GRID_W   = 120,
  parameter int GRID_H   = 68,
  parameter int PADDLE_H = 10,
  parameter int P1_X     = 1,
  parameter int P2_X     = 118,
  parameter int BALL_DIV = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic                 i_p1_up,
  input  logic                 i_p1_down,
  input  logic                 i_p2_up,
  input  logic                 i_p2_down,
  pong_state_engine_if.master  ram,
  output logic [3:0]           o_score_p1,
  output logic [3:0]           o_score_p2,
  output logic                 o_busy
);

  localparam logic [7:0] PMAX   = 8'(GRID_H - PADDLE_H);
  localparam logic [7:0] PY0    = 8'((GRID_H - PADDLE_H) / 2);
  localparam logic [7:0] XC     = 8'(GRID_W / 2);
  localparam logic [7:0] YC     = 8'(GRID_H / 2);
  localparam logic [7:0] XMAX   = 8'(GRID_W - 1);
  localparam logic [7:0] YMAX   = 8'(GRID_H - 1);
  localparam logic [7:0] P1X8   = 8'(P1_X);
  localparam logic [7:0] P2X8   = 8'(P2_X);
  localparam logic [7:0] PH8    = 8'(PADDLE_H);
  localparam logic [7:0] P1_HIT = 8'(P1_X + 1);
  localparam logic [7:0] P2_HIT = 8'(P2_X - 1);
  localparam logic [3:0] DIV_LAST = 4'(BALL_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_PADDLES, S_BALL, S_COLLIDE, S_WRITE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic [7:0]  bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards smaller coordinate
  logic        dy_n;
  logic [3:0]  div_q, div_d;
  logic [3:0]  s1_q, s1_d, s2_q, s2_d;
  logic        we_q, we_d, busy_q, busy_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  function automatic logic [7:0] paddle_step(logic [7:0] y, logic up, logic dn);
    if (up && !dn) return (y == 8'd0) ? 8'd0 : y - 8'd1;
    if (dn && !up) return (y >= PMAX) ? PMAX : y + 8'd1;
    return y;
  endfunction

  // 9-bit compare so py + PADDLE_H - 1 cannot wrap near the bottom edge
  function automatic logic in_span(logic [7:0] py, logic [7:0] y);
    logic [8:0] top;
    top = {1'b0, py} + 9'(PADDLE_H - 1);
    return ({1'b0, y} >= {1'b0, py}) && ({1'b0, y} <= top);
  endfunction

  function automatic logic [3:0] sat_inc(logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

  function automatic logic [7:0] rec_byte(logic [2:0] a, logic [7:0] y1,
                                          logic [7:0] y2, logic [7:0] bx,
                                          logic [7:0] by);
    case (a)
      3'd0:    return P1X8;
      3'd1:    return y1;
      3'd2:    return PH8;
      3'd3:    return P2X8;
      3'd4:    return y2;
      3'd5:    return PH8;
      3'd6:    return bx;
      default: return by;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    p1_y_d  = p1_y_q;
    p2_y_d  = p2_y_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    dy_n    = dy_q;
    div_d   = div_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    we_d    = we_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          state_d = S_PADDLES;
          busy_d  = 1'b1;
        end
      end
      S_PADDLES: begin
        p1_y_d  = paddle_step(p1_y_q, i_p1_up, i_p1_down);
        p2_y_d  = paddle_step(p2_y_q, i_p2_up, i_p2_down);
        state_d = S_BALL;
      end
      S_BALL: begin
        if (div_q >= DIV_LAST) begin
          div_d = 4'd0;
          if ((by_q == 8'd0 && dy_q) || (by_q == YMAX && !dy_q)) dy_n = ~dy_q;
          dy_d = dy_n;
          by_d = dy_n ? by_q - 8'd1 : by_q + 8'd1;
          bx_d = dx_q ? bx_q - 8'd1 : bx_q + 8'd1;
        end else begin
          div_d = div_q + 4'd1;
        end
        state_d = S_COLLIDE;
      end
      S_COLLIDE: begin
        // paddle hits are checked first so they win over a miss
        if (bx_q == P1_HIT && dx_q && in_span(p1_y_q, by_q)) begin
          dx_d = 1'b0;
        end else if (bx_q == P2_HIT && !dx_q && in_span(p2_y_q, by_q)) begin
          dx_d = 1'b1;
        end else if (bx_q == 8'd0) begin
          s2_d = sat_inc(s2_q);
          bx_d = XC;
          by_d = YC;
          dx_d = 1'b1;
        end else if (bx_q == XMAX) begin
          s1_d = sat_inc(s1_q);
          bx_d = XC;
          by_d = YC;
          dx_d = 1'b0;
        end
        state_d = S_WRITE;
        we_d    = 1'b1;
        addr_d  = 6'd0;
        data_d  = P1X8;
      end
      S_WRITE: begin
        if (addr_q == 6'd7) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          addr_d = addr_q + 6'd1;
          data_d = rec_byte(addr_q[2:0] + 3'd1, p1_y_q, p2_y_q, bx_q, by_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      p1_y_q  <= PY0;
      p2_y_q  <= PY0;
      bx_q    <= XC;
      by_q    <= YC;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      div_q   <= 4'd0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= 6'd0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      p1_y_q  <= p1_y_d;
      p2_y_q  <= p2_y_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      div_q   <= div_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ram.we      = we_q;
  assign ram.address = addr_q;
  assign ram.data    = data_q;
  assign o_score_p1  = s1_q;
  assign o_score_p2  = s2_q;
  assign o_busy      = busy_q;

endmodule
